// File: rtl/debug_dump_tx.sv
// Serializes NUM_WORDS debug words to the UART as bytes, LSB first, via tx_start/tx_done.
// Optional DEBUG_DUMP_CHECKSUM_EN appends one XOR checksum byte after the payload.
module debug_dump_tx #(
    parameter int BITS_SIZE  = 32,
    parameter int SIZE_TRAMA = 8,
    parameter int NUM_WORDS  = 16,
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  wire_clk_wz,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [IDX_W-1:0]      o_word_index,
    input  logic [BITS_SIZE-1:0]  i_word_data,
    output logic                  o_tx_start,
    output logic [SIZE_TRAMA-1:0] o_tx_data,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int NBYTES = BITS_SIZE / SIZE_TRAMA;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LATCH,
        S_SEND,
        S_WAIT,
`ifdef DEBUG_DUMP_CHECKSUM_EN
        S_CKSUM,
`endif
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BITS_SIZE-1:0]   shift_q, shift_d;
    logic                   done_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [SIZE_TRAMA-1:0]  xor_q, xor_d;
    logic                   ck_q, ck_d;
`endif

    // tx_done is registered, which gives the n+2 / n+4 restart gaps; only a WAIT-time pulse counts.
    always_ff @(posedge wire_clk_wz) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            xor_q   <= '0;
            ck_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= i_tx_done && (state_q == S_WAIT) && !done_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            xor_q   <= xor_d;
            ck_q    <= ck_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        xor_d   = xor_q;
        ck_d    = ck_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    xor_d   = '0;
                    ck_d    = 1'b0;
`endif
                end
            end
            S_LOAD:  state_d = S_LATCH;
            S_LATCH: begin
                shift_d = i_word_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                if (!ck_q) xor_d = xor_q ^ shift_q[SIZE_TRAMA-1:0];
`endif
            end
            S_WAIT: begin
                if (done_q) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    if (ck_q) state_d = S_FINISH;
                    else
`endif
                    if (cnt_q < LAST_BYTE) begin
                        shift_d = shift_q >> SIZE_TRAMA;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_SEND;
                    end else if (idx_q < LAST_WORD) begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_FINISH;
`endif
                    end
                end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            S_CKSUM: begin
                shift_d = BITS_SIZE'(xor_q);
                ck_d    = 1'b1;
                state_d = S_SEND;
            end
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_start   = (state_q == S_SEND);
        o_done       = (state_q == S_FINISH);
        o_busy       = (state_q != S_IDLE);
        o_tx_data    = shift_q[SIZE_TRAMA-1:0];
        o_word_index = idx_q;
    end
endmodule
